// File: rtl/dmem_uart_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path and a
// UART command channel ('W' addr d0..d3 / 'R' addr), stealing idle core cycles.
module dmem_uart_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 6,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  err_overrun
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT_MEM,
        SEND
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  op_wr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [1:0]            byte_cnt;
    logic [SW-1:0]         starve_cnt;
    logic                  err_q;
    logic                  uart_grant;
    logic                  starved;

    assign starved    = (starve_cnt == SW'(STARVE_LIMIT));
    assign uart_grant = (state == WAIT_MEM) && (!cpu_req || starved);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    state_nx = op_wr ? DATA : WAIT_MEM;
                end
            end
            DATA: begin
                if (rx_valid && byte_cnt == 2'd3) begin
                    state_nx = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (uart_grant) begin
                    state_nx = op_wr ? IDLE : SEND;
                end
            end
            SEND: begin
                if (tx_ready && byte_cnt == 2'd3) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // byte_cnt is shared: it counts DATA bytes on writes and SEND bytes on reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            shift_q    <= '0;
            byte_cnt   <= '0;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                        op_wr    <= (rx_data == CMD_WRITE);
                        byte_cnt <= '0;
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        addr_q     <= ADDR_WIDTH'(rx_data);
                        byte_cnt   <= '0;
                        starve_cnt <= '0;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        data_q[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt   <= byte_cnt + 2'd1;
                        starve_cnt <= '0;
                    end
                end
                WAIT_MEM: begin
                    if (rx_valid) begin
                        err_q <= 1'b1;
                    end
                    if (uart_grant) begin
                        byte_cnt <= '0;
                        if (!op_wr) begin
                            shift_q <= mem_rdata;
                        end
                    end else if (!starved) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                SEND: begin
                    if (rx_valid) begin
                        err_q <= 1'b1;
                    end
                    if (tx_ready) begin
                        shift_q  <= shift_q >> 8;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_req & cpu_we;
        if (uart_grant) begin
            mem_addr  = addr_q;
            mem_wdata = data_q;
            mem_we    = op_wr;
        end
    end

    assign cpu_rdata   = mem_rdata;
    assign cpu_stall   = uart_grant & cpu_req;
    assign tx_valid    = (state == SEND);
    assign tx_data     = shift_q[7:0];
    assign busy        = (state != IDLE);
    assign err_overrun = err_q;

endmodule

// File: tb/tb_dmem_uart_arbiter.sv
// Directed bench for dmem_uart_arbiter: memory model plus write/TX scoreboards
// checked from a negedge monitor, directed steps in a single initial block.
module tb_dmem_uart_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [5:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err_overrun;

    dmem_uart_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (6),
        .STARVE_LIMIT(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .err_overrun(err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: async read, write on posedge; pre_* lets the bench preload words.
    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    wr_t        w;
    logic [7:0] tb_byte;
    int         n_cmp = 0;
    int         n_err = 0;
    int         stall_cnt = 0;
    int         stall_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_stall) stall_cnt++;
        if (mem_we) begin
            check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(w.a));
                check("wr_data", mem_wdata, w.d);
            end
        end
        if (tx_valid && tx_ready) begin
            check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
            if (exp_tx.size() != 0) begin
                tb_byte = exp_tx.pop_front();
                check("tx_byte", 32'(tx_data), 32'(tb_byte));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        pre_we = 1'b1; pre_addr = 6'd9; pre_data = 32'h11223344;

        // Reset state; core path drives the memory port while in reset.
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd7; cpu_wdata = 32'h0BAD0BAD;
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_overrun), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd1);
        check("rst_mem_addr", 32'(mem_addr), 32'd7);
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();
        pre_we = 1'b0;
        rst = 1'b0;

        // Write with idle core.
        exp_wr.push_back('{a: 6'd5, d: 32'hDEADBEEF});
        send_byte(8'h57); send_byte(8'h05);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("wr_grant_we", 32'(mem_we), 32'd1);
        check("wr_grant_addr", 32'(mem_addr), 32'd5);
        check("wr_grant_data", mem_wdata, 32'hDEADBEEF);
        step();
        check("wr_busy_done", 32'(busy), 32'd0);
        check("wr_mem5", mem[5], 32'hDEADBEEF);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("wr_no_stall", 32'(stall_cnt), 32'd0);

        // Read of preloaded word 9, transmitter always ready.
        cpu_addr = 6'd9;
        #1;
        check("cpu_rdata", cpu_rdata, 32'h11223344);
        tx_ready = 1'b1;
        exp_tx.push_back(8'h44); exp_tx.push_back(8'h33);
        exp_tx.push_back(8'h22); exp_tx.push_back(8'h11);
        send_byte(8'h52); send_byte(8'h09);
        check("rd_wait_txv", 32'(tx_valid), 32'd0);
        check("rd_wait_busy", 32'(busy), 32'd1);
        step();
        check("rd_first_txv", 32'(tx_valid), 32'd1);
        check("rd_first_byte", 32'(tx_data), 32'h44);
        repeat (4) step();
        check("rd_busy_done", 32'(busy), 32'd0);
        check("rd_queue_empty", 32'(exp_tx.size()), 32'd0);

        // Starvation: core loads during the command, stores every blocked cycle.
        stall_base = stall_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd20; cpu_wdata = 32'h0000C0DE;
        for (int i = 0; i < 8; i++) exp_wr.push_back('{a: 6'd20, d: 32'h0000C0DE});
        exp_wr.push_back('{a: 6'd12, d: 32'h01234567});
        send_byte(8'h57); send_byte(8'h0C);
        send_byte(8'h67); send_byte(8'h45); send_byte(8'h23); send_byte(8'h01);
        cpu_we = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) step();
            check("starve_stall", 32'(cpu_stall), 32'(k == 9));
            if (k == 9) begin
                check("starve_addr", 32'(mem_addr), 32'd12);
                check("starve_data", mem_wdata, 32'h01234567);
            end
        end
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        check("starve_busy_done", 32'(busy), 32'd0);
        check("starve_one_stall", 32'(stall_cnt - stall_base), 32'd1);
        check("starve_mem12", mem[12], 32'h01234567);
        check("starve_queue_empty", 32'(exp_wr.size()), 32'd0);

        // Interleave: core store while the UART write waits one cycle.
        stall_base = stall_cnt;
        exp_wr.push_back('{a: 6'd3, d: 32'hAAAA5555});
        exp_wr.push_back('{a: 6'd4, d: 32'h0BADF00D});
        send_byte(8'h57); send_byte(8'h04);
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hAD); send_byte(8'h0B);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd3; cpu_wdata = 32'hAAAA5555;
        #1;
        check("il_core_addr", 32'(mem_addr), 32'd3);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        check("il_uart_addr", 32'(mem_addr), 32'd4);
        step();
        check("il_mem3", mem[3], 32'hAAAA5555);
        check("il_mem4", mem[4], 32'h0BADF00D);
        check("il_no_stall", 32'(stall_cnt - stall_base), 32'd0);

        // Garbage byte, then overrun during a stalled SEND.
        send_byte(8'h00);
        check("garbage_busy", 32'(busy), 32'd0);
        tx_ready = 1'b0;
        send_byte(8'h52); send_byte(8'h09);
        send_byte(8'h55);
        check("ovr_err", 32'(err_overrun), 32'd1);
        check("ovr_txv_hold", 32'(tx_valid), 32'd1);
        check("ovr_tx_hold", 32'(tx_data), 32'h44);
        exp_tx.push_back(8'h44); exp_tx.push_back(8'h33);
        exp_tx.push_back(8'h22); exp_tx.push_back(8'h11);
        tx_ready = 1'b1;
        repeat (4) step();
        check("ovr_busy_done", 32'(busy), 32'd0);
        check("ovr_err_sticky", 32'(err_overrun), 32'd1);

        // Reset in the middle of a write command.
        send_byte(8'h57); send_byte(8'h0A);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_err_before", 32'(err_overrun), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_busy_rst", 32'(busy), 32'd0);
        check("mid_err_rst", 32'(err_overrun), 32'd0);
        step();
        step();
        rst = 1'b0;
        exp_wr.push_back('{a: 6'd10, d: 32'h12345678});
        send_byte(8'h57); send_byte(8'h0A);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        step();
        check("post_rst_mem10", mem[10], 32'h12345678);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("final_wr_empty", 32'(exp_wr.size()), 32'd0);
        check("final_tx_empty", 32'(exp_tx.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
